// File: rtl/sram_word_master.sv
// Word-to-halfword master for an async 16-bit SRAM bus.
// Ports: core req/ack word side; addr/data/strobes SRAM side.
module sram_word_master #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [16:0] core_addr,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ack,
  output logic        core_busy,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] L_SETUP  = 3'd1;
  localparam logic [2:0] L_STROBE = 3'd2;
  localparam logic [2:0] H_SETUP  = 3'd3;
  localparam logic [2:0] H_STROBE = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [3:0] CNT_LAST =
    4'(WAIT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [16:0] a_q, a_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic [17:0] addr_q, addr_d;

  logic last;
  logic hi_en;
  logic setup;
  logic strobe;
  logic act;
  logic hi;

  assign last  = (cnt_q == CNT_LAST);
  assign hi_en = !we_q || (|be_q[3:2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    a_d     = a_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (core_req) begin
          we_d = core_we;
          a_d  = core_addr;
          be_d = core_be;
          wd_d = core_wdata;
          // Writes skip halves whose byte enables are all clear
          if (!core_we || (|core_be[1:0])) begin
            state_d = L_SETUP;
            addr_d  = {core_addr, 1'b0};
          end else if (|core_be[3:2]) begin
            state_d = H_SETUP;
            addr_d  = {core_addr, 1'b1};
          end else begin
            state_d = DONE;
          end
        end
      end
      L_SETUP: begin
        state_d = L_STROBE;
        cnt_d   = 4'd0;
      end
      L_STROBE: begin
        if (last) begin
          if (!we_q) rd_d[15:0] = data;
          if (hi_en) begin
            state_d = H_SETUP;
            addr_d  = {a_q, 1'b1};
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      H_SETUP: begin
        state_d = H_STROBE;
        cnt_d   = 4'd0;
      end
      H_STROBE: begin
        if (last) begin
          if (!we_q) rd_d[31:16] = data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      a_q     <= 17'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      addr_q  <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end

  // Pins decode straight from the state flop so that reset
  // releases the bus without waiting for a clock.
  assign setup  = (state_q == L_SETUP)
               || (state_q == H_SETUP);
  assign strobe = (state_q == L_STROBE)
               || (state_q == H_STROBE);
  assign act    = setup || strobe;
  assign hi     = (state_q == H_SETUP)
               || (state_q == H_STROBE);

  assign chip_en = !act;
  assign wre     = !(strobe && we_q);
  assign oute    = !(strobe && !we_q);

  always_comb begin
    lb_mask = 1'b1;
    hb_mask = 1'b1;
    if (act) begin
      if (we_q) begin
        lb_mask = hi ? !be_q[2] : !be_q[0];
        hb_mask = hi ? !be_q[3] : !be_q[1];
      end else begin
        lb_mask = 1'b0;
        hb_mask = 1'b0;
      end
    end
  end

  assign data = (act && we_q)
              ? (hi ? wd_q[31:16] : wd_q[15:0])
              : 16'hzzzz;

  assign addr       = addr_q;
  assign core_rdata = rd_q;
  assign core_ack   = (state_q == DONE);
  assign core_busy  = (state_q != IDLE);

endmodule
